// File: rtl/branch_pkg.sv
// branch_pkg: branch op / funct3 encodings and 2-bit predictor counter states
package branch_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_COND = 2'b01,
        OP_JAL  = 2'b10,
        OP_JALR = 2'b11
    } branch_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        return taken ? ((cnt == CNT_ST) ? CNT_ST : cnt + 2'd1)
                     : ((cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: actual branch outcome, target and correct next PC
module branch_resolve
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [1:0]      op,
    input  logic [2:0]      funct3,
    input  logic            z,
    input  logic            s,
    input  logic            c,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] next_pc
);

    logic cond_taken;

    always_comb begin
        cond_taken = (funct3 == F3_BEQ)  ? z  :
                     (funct3 == F3_BNE)  ? !z :
                     (funct3 == F3_BLT)  ? s  :
                     (funct3 == F3_BGE)  ? !s :
                     (funct3 == F3_BLTU) ? c  : !c;
        taken   = (op == OP_COND) ? cond_taken : (op != OP_NONE);
        target  = (op == OP_JALR) ? ((rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0}) : pc + imm;
        next_pc = taken ? target : pc + XLEN'(4);
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: fetch PC register, direct-mapped BTB predictor and mispredict redirect
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              BTB_ENTRIES  = 16,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    output logic [XLEN-1:0]      fetch_pc,
    output logic                 pred_taken,
    output logic [XLEN-1:0]      pred_target,
    input  logic                 res_valid,
    input  logic [XLEN-1:0]      res_pc,
    input  logic [XLEN-1:0]      res_imm,
    input  logic [XLEN-1:0]      res_rs1,
    input  logic [1:0]           res_branch_op,
    input  logic [2:0]           res_branch_type,
    input  logic                 res_z,
    input  logic                 res_s,
    input  logic                 res_c,
    input  logic                 res_pred_taken,
    input  logic [XLEN-1:0]      res_pred_target,
    output logic                 redirect,
    output logic [XLEN-1:0]      redirect_pc,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_next_pc;

    branch_resolve #(.XLEN(XLEN)) u_resolve (
        .pc      (res_pc),
        .imm     (res_imm),
        .rs1     (res_rs1),
        .op      (res_branch_op),
        .funct3  (res_branch_type),
        .z       (res_z),
        .s       (res_s),
        .c       (res_c),
        .taken   (res_taken),
        .target  (res_target),
        .next_pc (res_next_pc)
    );

    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
    logic [1:0]       btb_cnt    [BTB_ENTRIES];

    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             f_hit, r_hit, res_branch, btb_write;
    logic [XLEN-1:0]  next_fetch_pc;

    // Lookup reads the array registers directly, so a same-cycle update is not yet visible.
    always_comb begin
        f_idx         = fetch_pc[IDX_W+1:2];
        f_tag         = fetch_pc[XLEN-1:IDX_W+2];
        f_hit         = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
        pred_taken    = f_hit && btb_cnt[f_idx][1];
        pred_target   = f_hit ? btb_target[f_idx] : fetch_pc + XLEN'(4);
        r_idx         = res_pc[IDX_W+1:2];
        r_tag         = res_pc[XLEN-1:IDX_W+2];
        r_hit         = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
        res_branch    = res_valid && (res_branch_op != OP_NONE);
        btb_write     = res_branch && (res_taken || r_hit);
        redirect      = res_valid && ((res_branch_op == OP_NONE) ? res_pred_taken :
                        (res_taken != res_pred_taken) || (res_taken && (res_target != res_pred_target)));
        redirect_pc   = res_next_pc;
        next_fetch_pc = redirect ? redirect_pc : stall ? fetch_pc :
                        pred_taken ? pred_target : fetch_pc + XLEN'(4);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc         <= RESET_VECTOR;
            branch_count     <= '0;
            mispredict_count <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_cnt[i]   <= CNT_SNT;
            end
        end else begin
            fetch_pc <= next_fetch_pc;
            if (res_branch && !(&branch_count))
                branch_count <= branch_count + CNT_WIDTH'(1);
            if (redirect && !(&mispredict_count))
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
            if (btb_write) begin
                btb_valid[r_idx] <= 1'b1;
                btb_cnt[r_idx]   <= r_hit ? cnt_update(btb_cnt[r_idx], res_taken) : CNT_WT;
            end
        end
    end

    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (reset_n && btb_write && res_taken) begin
            btb_tag[r_idx]    <= r_tag;
            btb_target[r_idx] <= res_target;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: scoreboard-driven checks of fetch, prediction, redirect and counters
module tb_branch_predict_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n, stall, res_valid, res_z, res_s, res_c, res_pred_taken;
    logic [31:0]   res_pc, res_imm, res_rs1, res_pred_target;
    logic [1:0]    res_branch_op;
    logic [2:0]    res_branch_type;
    logic [31:0]   fetch_pc, pred_target, redirect_pc;
    logic          pred_taken, redirect;
    logic [CW-1:0] branch_count, mispredict_count;

    int           passed = 0;
    int           total = 0;
    logic [127:0] exp_q[$];
    logic [127:0] e;

    branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(16), .RESET_VECTOR(32'h0), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall),
        .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_imm(res_imm), .res_rs1(res_rs1),
        .res_branch_op(res_branch_op), .res_branch_type(res_branch_type),
        .res_z(res_z), .res_s(res_s), .res_c(res_c),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_outcome(input logic [1:0] op, input logic [2:0] f3,
                                                input logic [31:0] pc, imm, rs1, input logic z, s, c);
        logic t;
        logic [31:0] g;
        case (op)
            2'b00: t = 1'b0;
            2'b01: case (f3)
                3'd0: t = z;
                3'd1: t = !z;
                3'd4: t = s;
                3'd5: t = !s;
                3'd6: t = c;
                default: t = !c;
            endcase
            default: t = 1'b1;
        endcase
        g = (op == 2'b11) ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
        return {t, g};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        res_valid = 0; res_branch_op = 0; res_branch_type = 0;
        res_pc = 0; res_imm = 0; res_rs1 = 0;
        res_z = 0; res_s = 0; res_c = 0;
        res_pred_taken = 0; res_pred_target = 0;
    endtask

    task automatic drive_res(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc, imm, rs1,
                             input logic z, s, c, pt, input logic [31:0] ptg);
        res_valid = 1; res_branch_op = op; res_branch_type = f3;
        res_pc = pc; res_imm = imm; res_rs1 = rs1;
        res_z = z; res_s = s; res_c = c;
        res_pred_taken = pt; res_pred_target = ptg;
    endtask

    task automatic apply_reset;
        reset_n = 0; stall = 0;
        idle();
        tick();
        tick();
        reset_n = 1;
    endtask

    task automatic test_reset;
        reset_n = 0; stall = 1;
        drive_res(2'b10, 3'd0, 32'h100, 32'h40, 32'h0, 0, 0, 0, 0, 32'h0);
        exp_q.push_back(128'({1'b0, 32'h4, 32'h0}));
        exp_q.push_back(128'({4'd0, 4'd0}));
        exp_q.push_back(128'({1'b1, 32'h140}));
        tick();
        e = exp_q.pop_front(); total++;
        if ({pred_taken, pred_target, fetch_pc} !== e[64:0])
            $display("FAIL reset_fetch: got %h want %h", {pred_taken, pred_target, fetch_pc}, e[64:0]);
        else passed++;
        e = exp_q.pop_front(); total++;
        if ({branch_count, mispredict_count} !== e[7:0])
            $display("FAIL reset_counts: got %h want %h", {branch_count, mispredict_count}, e[7:0]);
        else passed++;
        e = exp_q.pop_front(); total++;
        if ({redirect, redirect_pc} !== e[32:0])
            $display("FAIL reset_redirect_comb: got %h want %h", {redirect, redirect_pc}, e[32:0]);
        else passed++;
    endtask

    task automatic test_seq_fetch;
        apply_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(128'({1'b0, 32'(i * 4)}));
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front(); total++;
            if ({pred_taken, fetch_pc} !== e[32:0])
                $display("FAIL seq_fetch_%0d: got %h want %h", i, {pred_taken, fetch_pc}, e[32:0]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_beq_alloc;
        apply_reset();
        drive_res(2'b01, 3'd0, 32'h10, 32'h20, 32'h0, 1, 0, 0, 0, 32'h0);
        exp_q.push_back(128'({1'b1, 32'h30}));
        #1;
        e = exp_q.pop_front(); total++;
        if ({redirect, redirect_pc} !== e[32:0])
            $display("FAIL beq_redirect: got %h want %h", {redirect, redirect_pc}, e[32:0]);
        else passed++;
        tick();
        drive_res(2'b00, 3'd0, 32'hC, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0);
        exp_q.push_back(128'({32'h30, 1'b1, 32'h10}));
        #1;
        e = exp_q.pop_front(); total++;
        if ({fetch_pc, redirect, redirect_pc} !== e[64:0])
            $display("FAIL nop_redirect: got %h want %h", {fetch_pc, redirect, redirect_pc}, e[64:0]);
        else passed++;
        tick();
        idle();
        exp_q.push_back(128'({32'h10, 1'b1, 32'h30, 4'd1, 4'd2}));
        #1;
        e = exp_q.pop_front(); total++;
        if ({fetch_pc, pred_taken, pred_target, branch_count, mispredict_count} !== e[72:0])
            $display("FAIL beq_predict: got %h want %h",
                     {fetch_pc, pred_taken, pred_target, branch_count, mispredict_count}, e[72:0]);
        else passed++;
        exp_q.push_back(128'(32'h30));
        tick();
        e = exp_q.pop_front(); total++;
        if (fetch_pc !== e[31:0]) $display("FAIL beq_follow: got %h want %h", fetch_pc, e[31:0]);
        else passed++;
    endtask

    task automatic test_jalr;
        apply_reset();
        drive_res(2'b11, 3'd0, 32'h40, 32'h4, 32'h1001, 0, 0, 0, 1, 32'h1004);
        exp_q.push_back(128'({1'b0, 32'h1004}));
        exp_q.push_back(128'({32'h4, 4'd1, 4'd0}));
        #1;
        e = exp_q.pop_front(); total++;
        if ({redirect, redirect_pc} !== e[32:0])
            $display("FAIL jalr_ok_redirect: got %h want %h", {redirect, redirect_pc}, e[32:0]);
        else passed++;
        tick();
        idle();
        e = exp_q.pop_front(); total++;
        if ({fetch_pc, branch_count, mispredict_count} !== e[39:0])
            $display("FAIL jalr_ok_counts: got %h want %h", {fetch_pc, branch_count, mispredict_count}, e[39:0]);
        else passed++;
        drive_res(2'b11, 3'd0, 32'h40, 32'h4, 32'h1001, 0, 0, 0, 1, 32'h1000);
        exp_q.push_back(128'({1'b1, 32'h1004}));
        exp_q.push_back(128'({32'h1004, 4'd2, 4'd1}));
        #1;
        e = exp_q.pop_front(); total++;
        if ({redirect, redirect_pc} !== e[32:0])
            $display("FAIL jalr_bad_target: got %h want %h", {redirect, redirect_pc}, e[32:0]);
        else passed++;
        tick();
        idle();
        e = exp_q.pop_front(); total++;
        if ({fetch_pc, branch_count, mispredict_count} !== e[39:0])
            $display("FAIL jalr_bad_counts: got %h want %h", {fetch_pc, branch_count, mispredict_count}, e[39:0]);
        else passed++;
    endtask

    task automatic test_counter;
        logic [8:0] tk = 9'b110000111;
        logic [8:0] ex = 9'b100001111;
        apply_reset();
        stall = 1;
        drive_res(2'b00, 3'd0, 32'hC, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive_res((i < 3) ? 2'b10 : 2'b01, 3'd1, 32'h10, 32'h70, 32'h0, !tk[i], 0, 0, tk[i], 32'h80);
            if (i == 0) begin
                exp_q.push_back(128'({1'b0, 32'h14}));
                #1;
                e = exp_q.pop_front(); total++;
                if ({pred_taken, pred_target} !== e[32:0])
                    $display("FAIL same_cycle_old: got %h want %h", {pred_taken, pred_target}, e[32:0]);
                else passed++;
            end
            exp_q.push_back(128'({ex[i], 32'h80}));
            tick();
            e = exp_q.pop_front(); total++;
            if ({pred_taken, pred_target} !== e[32:0])
                $display("FAIL counter_step_%0d: got %h want %h", i, {pred_taken, pred_target}, e[32:0]);
            else passed++;
        end
        idle();
        exp_q.push_back(128'({32'h10, 4'd9, 4'd1}));
        #1;
        e = exp_q.pop_front(); total++;
        if ({fetch_pc, branch_count, mispredict_count} !== e[39:0])
            $display("FAIL counter_totals: got %h want %h", {fetch_pc, branch_count, mispredict_count}, e[39:0]);
        else passed++;
        stall = 0;
    endtask

    task automatic test_stall_redirect;
        apply_reset();
        stall = 1;
        drive_res(2'b00, 3'd0, 32'h1FC, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0);
        for (int i = 0; i < 3; i++) exp_q.push_back(128'(32'h200));
        exp_q.push_back(128'(32'h204));
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall = 0;
            tick();
            idle();
            e = exp_q.pop_front(); total++;
            if (fetch_pc !== e[31:0]) $display("FAIL stall_step_%0d: got %h want %h", i, fetch_pc, e[31:0]);
            else passed++;
        end
    endtask

    task automatic test_tag_alias;
        apply_reset();
        stall = 1;
        drive_res(2'b00, 3'd0, 32'hC, 32'h0, 32'h0, 0, 0, 0, 1, 32'h0);
        tick();
        drive_res(2'b10, 3'd0, 32'h10, 32'h70, 32'h0, 0, 0, 0, 1, 32'h80);
        exp_q.push_back(128'({1'b1, 32'h80}));
        tick();
        e = exp_q.pop_front(); total++;
        if ({pred_taken, pred_target} !== e[32:0])
            $display("FAIL alias_hit: got %h want %h", {pred_taken, pred_target}, e[32:0]);
        else passed++;
        drive_res(2'b10, 3'd0, 32'h50, 32'h10, 32'h0, 0, 0, 0, 1, 32'h60);
        exp_q.push_back(128'({1'b0, 32'h14}));
        tick();
        idle();
        e = exp_q.pop_front(); total++;
        if ({pred_taken, pred_target} !== e[32:0])
            $display("FAIL alias_evict: got %h want %h", {pred_taken, pred_target}, e[32:0]);
        else passed++;
        stall = 0;
    endtask

    task automatic test_resolve_random;
        logic [1:0] op;
        logic [2:0] f3;
        logic [31:0] pc, imm, rs1, ptg, nxt;
        logic z, s, c, pt, v, red;
        logic [32:0] o;
        logic [3:0] bcnt, mcnt;
        apply_reset();
        bcnt = 0; mcnt = 0;
        for (int i = 0; i < 64; i++) begin
            v = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
            pc = $urandom; imm = $urandom; rs1 = $urandom;
            z = 1'($urandom); s = 1'($urandom); c = 1'($urandom); pt = 1'($urandom);
            o = ref_outcome(op, f3, pc, imm, rs1, z, s, c);
            ptg = $urandom_range(0, 1) ? o[31:0] : $urandom;
            nxt = o[32] ? o[31:0] : pc + 32'd4;
            red = v && ((op == 2'b00) ? pt : ((o[32] != pt) || (o[32] && o[31:0] != ptg)));
            drive_res(op, f3, pc, imm, rs1, z, s, c, pt, ptg);
            res_valid = v;
            exp_q.push_back(128'({red, nxt}));
            #1;
            e = exp_q.pop_front(); total++;
            if (redirect !== e[32] || (e[32] && redirect_pc !== e[31:0]))
                $display("FAIL rand_%0d op=%0d f3=%0d: got %h want %h", i, op, f3, {redirect, redirect_pc}, e[32:0]);
            else passed++;
            if (v && op != 2'b00 && bcnt != 4'hF) bcnt++;
            if (red && mcnt != 4'hF) mcnt++;
            tick();
        end
        idle();
        exp_q.push_back(128'({bcnt, mcnt}));
        #1;
        e = exp_q.pop_front(); total++;
        if ({branch_count, mispredict_count} !== e[7:0])
            $display("FAIL rand_counts: got %h want %h", {branch_count, mispredict_count}, e[7:0]);
        else passed++;
    endtask

    initial begin
        reset_n = 0; stall = 0;
        idle();
        test_reset();
        test_seq_fetch();
        test_beq_alloc();
        test_jalr();
        test_counter();
        test_stall_redirect();
        test_tag_alias();
        test_resolve_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
